// File: rtl/cv32e40p_fpu_arbiter.sv
// Round-robin arbiter sharing one FPNEW-style FPU between NUM_REQ requesters.
// Optional perf counters are enabled with the CV32E40P_FPU_ARB_PERF_EN macro.
module cv32e40p_fpu_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned PAYLOAD_W       = 101,
    parameter int unsigned RES_W           = 37,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned TagW           = ID_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*4-1:0]         req_op_i,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
    output logic                         fpu_valid_o,
    input  logic                         fpu_ready_i,
    output logic [3:0]                   fpu_op_o,
    output logic [PAYLOAD_W-1:0]         fpu_payload_o,
    output logic [TagW-1:0]              fpu_tag_o,
    input  logic                         fpu_rvalid_i,
    output logic                         fpu_rready_o,
    input  logic [RES_W-1:0]             fpu_result_i,
    input  logic [TagW-1:0]              fpu_rtag_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [RES_W-1:0]             rsp_result_o,
    output logic                         busy_o
`ifdef CV32E40P_FPU_ARB_PERF_EN
    ,
    output logic [31:0]                  contention_cnt_o,
    output logic [31:0]                  issue_cnt_o
`endif
);

    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW:0] MaxCnt = (CntW + 1)'(MAX_OUTSTANDING);
    localparam logic [3:0]  OpDiv  = 4'd4;
    localparam logic [3:0]  OpSqrt = 4'd5;

    typedef enum logic [0:0] {StEmpty, StFull} slot_state_e;

    slot_state_e          state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [TagW-1:0]      tag_q, tag_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [CntW-1:0]      outst_q, outst_d;
    logic                 div_busy_q, div_busy_d;

    logic                 issue_hs, rsp_hs, can_load, slot_is_div, room;
    logic [CntW:0]        outst_after;
    logic [NUM_REQ-1:0]   eligible;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic [3:0]           op_sel;
    logic [PAYLOAD_W-1:0] payload_sel;
    logic [ID_W-1:0]      rtag_id;

    function automatic logic is_divsqrt(input logic [3:0] op);
        return (op == OpDiv) || (op == OpSqrt);
    endfunction

    assign issue_hs    = (state_q == StFull) & fpu_ready_i;
    assign can_load    = (state_q == StEmpty) | issue_hs;
    assign slot_is_div = (state_q == StFull) & tag_q[ID_W];
    // Count the op leaving the slot this cycle, so a new load can never push past the cap.
    assign outst_after = {1'b0, outst_q} + {{CntW{1'b0}}, issue_hs};
    assign room        = outst_after < MaxCnt;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = ~rst & req_valid_i[i] & can_load & room;
            if (is_divsqrt(req_op_i[i*4 +: 4]) && (div_busy_q || slot_is_div)) begin
                eligible[i] = 1'b0;
            end
        end
    end

    // Round robin: lowest eligible index at or above the pointer, else lowest below it.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && eligible[i] && (ID_W'(i) >= rr_q)) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && eligible[i] && (ID_W'(i) < rr_q)) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        op_sel      = '0;
        payload_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_id == ID_W'(i))) begin
                req_ready_o[i] = 1'b1;
                op_sel         = req_op_i[i*4 +: 4];
                payload_sel    = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_valid) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = grant_id + ID_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        payload_d = payload_q;
        tag_d     = tag_q;
        unique case (state_q)
            StEmpty: if (grant_valid) state_d = StFull;
            StFull:  if (fpu_ready_i && !grant_valid) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (grant_valid) begin
            op_d      = op_sel;
            payload_d = payload_sel;
            tag_d     = {is_divsqrt(op_sel), grant_id};
        end
    end

    // Response path; IDs beyond NUM_REQ keep the default ready so the result is dropped.
    assign rtag_id      = fpu_rtag_i[ID_W-1:0];
    assign rsp_result_o = fpu_result_i;

    always_comb begin
        rsp_valid_o  = '0;
        fpu_rready_o = ~rst;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (rtag_id == ID_W'(k)) begin
                rsp_valid_o[k] = fpu_rvalid_i & ~rst;
                fpu_rready_o   = rsp_ready_i[k] & ~rst;
            end
        end
    end

    assign rsp_hs = fpu_rvalid_i & fpu_rready_o;

    always_comb begin
        outst_d = outst_q;
        if (issue_hs && !rsp_hs) begin
            outst_d = outst_q + CntW'(1);
        end else if (!issue_hs && rsp_hs && (outst_q != '0)) begin
            outst_d = outst_q - CntW'(1);
        end
    end

    always_comb begin
        div_busy_d = div_busy_q;
        if (issue_hs && tag_q[ID_W]) begin
            div_busy_d = 1'b1;
        end else if (rsp_hs && fpu_rtag_i[ID_W]) begin
            div_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            op_q       <= '0;
            payload_q  <= '0;
            tag_q      <= '0;
            rr_q       <= '0;
            outst_q    <= '0;
            div_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            payload_q  <= payload_d;
            tag_q      <= tag_d;
            rr_q       <= rr_d;
            outst_q    <= outst_d;
            div_busy_q <= div_busy_d;
        end
    end

    assign fpu_valid_o   = (state_q == StFull);
    assign fpu_op_o      = op_q;
    assign fpu_payload_o = payload_q;
    assign fpu_tag_o     = tag_q;
    assign busy_o        = (state_q == StFull) | (outst_q != '0);

`ifdef CV32E40P_FPU_ARB_PERF_EN
    logic [31:0] contention_q, contention_d;
    logic [31:0] issue_cnt_q, issue_cnt_d;

    always_comb begin
        contention_d = contention_q;
        issue_cnt_d  = issue_cnt_q;
        if ((|(req_valid_i & ~req_ready_o)) && (contention_q != '1)) begin
            contention_d = contention_q + 32'd1;
        end
        if (issue_hs && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            contention_q <= '0;
            issue_cnt_q  <= '0;
        end else begin
            contention_q <= contention_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end

    assign contention_cnt_o = contention_q;
    assign issue_cnt_o      = issue_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_fpu_arbiter.sv
// Directed bench for cv32e40p_fpu_arbiter with NUM_REQ=2 and MAX_OUTSTANDING=2.
module tb_cv32e40p_fpu_arbiter;

    localparam logic [3:0]     OpAdd  = 4'd2;
    localparam logic [3:0]     OpMul  = 4'd3;
    localparam logic [3:0]     OpDiv  = 4'd4;
    localparam logic [3:0]     OpSqrt = 4'd5;
    localparam logic [100:0]   P0     = 101'h1_2345_6789_ABCD;
    localparam logic [100:0]   P1     = 101'h0_FEDC_BA98_7654;
    localparam logic [36:0]    Res    = 37'h1_2345_6789;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [7:0]   req_op;
    logic [201:0] req_payload;
    logic         fpu_valid, fpu_ready;
    logic [3:0]   fpu_op;
    logic [100:0] fpu_payload;
    logic [1:0]   fpu_tag;
    logic         fpu_rvalid, fpu_rready;
    logic [36:0]  fpu_result;
    logic [1:0]   fpu_rtag;
    logic [1:0]   rsp_valid, rsp_ready;
    logic [36:0]  rsp_result;
    logic         busy;

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    cv32e40p_fpu_arbiter #(
        .NUM_REQ        (2),
        .PAYLOAD_W      (101),
        .RES_W          (37),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_payload_i(req_payload),
        .fpu_valid_o  (fpu_valid),
        .fpu_ready_i  (fpu_ready),
        .fpu_op_o     (fpu_op),
        .fpu_payload_o(fpu_payload),
        .fpu_tag_o    (fpu_tag),
        .fpu_rvalid_i (fpu_rvalid),
        .fpu_rready_o (fpu_rready),
        .fpu_result_i (fpu_result),
        .fpu_rtag_i   (fpu_rtag),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .busy_o       (busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] pend[$];
    int         grants, issued, nissue;
    logic       exp_next_valid;
    logic       exp_id;
    logic [3:0] bp_pat;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        req_valid   = '0;
        req_op      = '0;
        req_payload = {P1, P0};
        fpu_ready   = 1'b0;
        fpu_rvalid  = 1'b0;
        fpu_result  = Res;
        fpu_rtag    = '0;
        rsp_ready   = '0;

        // Reset then idle
        tick();
        tick();
        #1;
        check_eq("rst_outputs", {fpu_valid, fpu_op, fpu_tag, req_ready, rsp_valid, fpu_rready, busy},
                 '0);
        check_eq("rst_payload", fpu_payload, '0);
        rst = 1'b0;
        tick();
        #1;
        check_eq("idle", {fpu_valid, req_ready, busy}, '0);

        // Fairness with a responder returning issued tags in order
        tick();
        req_op         = {OpAdd, OpAdd};
        fpu_ready      = 1'b1;
        rsp_ready      = 2'b11;
        req_valid      = 2'b11;
        grants         = 0;
        issued         = 0;
        exp_next_valid = 1'b0;
        exp_id         = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (grants >= 4) req_valid = 2'b00;
            if (pend.size() > 0) begin
                fpu_rvalid = 1'b1;
                fpu_rtag   = pend[0];
            end else begin
                fpu_rvalid = 1'b0;
            end
            #1;
            if (exp_next_valid) begin
                check_eq("fair_valid", fpu_valid, 1'b1);
                check_eq("fair_tag", fpu_tag, {1'b0, exp_id});
                check_eq("fair_payload", fpu_payload, exp_id ? P1 : P0);
                exp_next_valid = 1'b0;
            end
            if (req_ready != 2'b00) begin
                check_eq("fair_grant", req_ready, (grants % 2 == 0) ? 2'b01 : 2'b10);
                exp_id         = req_ready[1];
                exp_next_valid = 1'b1;
                grants++;
            end
            if (fpu_rvalid && fpu_rready) void'(pend.pop_front());
            if (fpu_valid && fpu_ready) begin
                pend.push_back(fpu_tag);
                issued++;
            end
            tick();
        end
        fpu_rvalid = 1'b0;
        #1;
        check_eq("fair_grants", grants, 4);
        check_eq("fair_issued", issued, 4);
        check_eq("fair_drain_busy", busy, 1'b0);

        // Issue backpressure on req0 MUL
        tick();
        req_op    = {OpAdd, OpMul};
        req_valid = 2'b01;
        fpu_ready = 1'b0;
        rsp_ready = 2'b00;
        #1;
        check_eq("bp_grant", req_ready, 2'b01);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("bp_hold", {fpu_valid, fpu_op, fpu_tag, req_ready}, {1'b1, OpMul, 2'b00, 2'b00});
            check_eq("bp_payload", fpu_payload, P0);
            tick();
        end
        req_valid = 2'b00;
        nissue    = 0;
        bp_pat    = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            fpu_ready = bp_pat[c];
            #1;
            if (fpu_valid && fpu_ready) nissue++;
            tick();
        end
        fpu_ready = 1'b0;
        #1;
        check_eq("bp_one_issue", nissue, 1);
        check_eq("bp_outstanding", {fpu_valid, busy}, 2'b01);

        // Result backpressure on requester 0
        fpu_rvalid = 1'b1;
        fpu_rtag   = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("rbp_hold", {fpu_rready, rsp_valid, busy}, {1'b0, 2'b01, 1'b1});
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        check_eq("rbp_accept", {fpu_rready, rsp_valid}, {1'b1, 2'b01});
        check_eq("rbp_result", rsp_result, Res);
        tick();
        fpu_rvalid = 1'b0;
        rsp_ready  = 2'b00;
        #1;
        check_eq("rbp_done", busy, 1'b0);

        // Outstanding cap of two
        tick();
        req_op    = {OpAdd, OpAdd};
        req_valid = 2'b11;
        fpu_ready = 1'b1;
        nissue    = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 0) check_eq("cap_first", req_ready, 2'b10);
            if (c == 1) check_eq("cap_second", req_ready, 2'b01);
            if (fpu_valid && fpu_ready) nissue++;
            if (c == 5) check_eq("cap_blocked", req_ready, 2'b00);
            tick();
        end
        check_eq("cap_issues", nissue, 2);
        fpu_rvalid = 1'b1;
        fpu_rtag   = 2'b01;
        rsp_ready  = 2'b11;
        #1;
        check_eq("cap_rsp_route", {rsp_valid, fpu_rready, req_ready}, {2'b10, 1'b1, 2'b00});
        tick();
        fpu_rvalid = 1'b0;
        #1;
        check_eq("cap_reopen", req_ready, 2'b10);
        tick();
        nissue = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (fpu_valid && fpu_ready) nissue++;
            tick();
        end
        #1;
        check_eq("cap_one_more", nissue, 1);
        check_eq("cap_reblocked", req_ready, 2'b00);
        req_valid  = 2'b00;
        fpu_rvalid = 1'b1;
        fpu_rtag   = 2'b00;
        tick();
        tick();
        fpu_rvalid = 1'b0;
        #1;
        check_eq("cap_drain", busy, 1'b0);

        // DIV/SQRT serialisation
        tick();
        req_op    = {OpSqrt, OpDiv};
        req_valid = 2'b01;
        #1;
        check_eq("div_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        #1;
        check_eq("sqrt_blk_slot", req_ready, 2'b00);
        tick();
        #1;
        check_eq("sqrt_blk_busy", req_ready, 2'b00);
        tick();
        req_op[7:4] = OpAdd;
        #1;
        check_eq("add_not_blk", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("add_issue", {fpu_valid, fpu_tag}, {1'b1, 2'b01});
        tick();
        req_op[7:4] = OpSqrt;
        req_valid   = 2'b10;
        fpu_rvalid  = 1'b1;
        fpu_rtag    = 2'b01;
        #1;
        check_eq("sqrt_blk_cap", req_ready, 2'b00);
        tick();
        fpu_rvalid = 1'b0;
        #1;
        check_eq("sqrt_blk_after_add", req_ready, 2'b00);
        tick();
        fpu_rvalid = 1'b1;
        fpu_rtag   = 2'b10;
        #1;
        check_eq("div_rsp", {rsp_valid, fpu_rready, req_ready}, {2'b01, 1'b1, 2'b00});
        tick();
        fpu_rvalid = 1'b0;
        #1;
        check_eq("sqrt_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("sqrt_issue", {fpu_valid, fpu_op, fpu_tag}, {1'b1, OpSqrt, 2'b11});
        tick();
        fpu_rvalid = 1'b1;
        fpu_rtag   = 2'b11;
        tick();
        fpu_rvalid = 1'b0;
        #1;
        check_eq("div_drain", busy, 1'b0);

        // Reset with a full slot
        tick();
        req_op[3:0] = OpAdd;
        req_valid   = 2'b01;
        fpu_ready   = 1'b0;
        tick();
        req_valid = 2'b00;
        rst       = 1'b1;
        #1;
        check_eq("pre_rst_busy", busy, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_mid", {busy, fpu_valid, fpu_tag, fpu_op}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
